telemetry_framer: RTL and testbench
===================================

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

Interface
REQ-001 The block SHALL expose parameter AUTO_PERIOD, default 32'd0, meaning the number of clk cycles between self-triggered frames (0 = auto-trigger disabled).
REQ-002 The block SHALL expose parameter ACK_TIMEOUT, default 16'd64, meaning the maximum clk cycles to wait for tx_busy to rise after a byte strobe.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, with asynchronous assertion, active-low reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to emit one frame.
REQ-006 The block SHALL have ports te_data, hu_data and sm_data, input, 24 each, carrying three ASCII digits each, MSB byte first.
REQ-007 The block SHALL have port tx_busy, input, 1, driven high by the downstream UART transmitter while it shifts a byte.
REQ-008 The block SHALL have port tx_data, output, 8, the byte presented to the UART transmitter.
REQ-009 The block SHALL have port tx_wr, output, 1, a one-cycle write strobe qualifying tx_data.
REQ-010 The block SHALL have port busy, output, 1, high from frame acceptance until the last byte completes.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse after the last byte completes.

Function
REQ-012 The frame SHALL be 'T',te[23:16],te[15:8],'.',te[7:0],',','H',hu[23:16],hu[15:8],hu[7:0],',','S',sm[23:16],sm[15:8],sm[7:0],8'h0D,8'h0A; this is 17 bytes.
REQ-013 te_data, hu_data and sm_data SHALL be captured into snapshot registers in the cycle a frame is accepted, and the whole frame SHALL use the snapshot.
REQ-014 The FSM SHALL have states IDLE, LOAD, STROBE, WAIT_ACK, WAIT_DONE and FINISH.
REQ-015 IDLE->LOAD SHALL occur on start=1 or on a pending auto request; busy SHALL rise in LOAD.
REQ-016 LOAD->STROBE SHALL take one cycle, with the byte index cleared to 0.
REQ-017 In STROBE, tx_wr SHALL pulse for one cycle with tx_data = frame[index], and only when tx_busy=0; otherwise the FSM SHALL stay in STROBE.
REQ-018 WAIT_ACK->WAIT_DONE SHALL occur on tx_busy=1, or after ACK_TIMEOUT cycles without tx_busy=1.
REQ-019 WAIT_DONE SHALL wait for tx_busy=0, then increment index and return to STROBE, or go to FINISH after the last byte.
REQ-020 FINISH SHALL pulse done for one cycle, drop busy and return to IDLE, so that first tx_wr occurs exactly 2 cycles after start in IDLE when tx_busy=0.
REQ-021 tx_data SHALL hold its value from strobe until the next strobe.
REQ-022 A start received while busy=1 SHALL be ignored and not queued.
REQ-023 With AUTO_PERIOD>0, a free-running counter SHALL wrap at AUTO_PERIOD-1 and set a single pending flag that is cleared on acceptance; further wraps while pending SHALL not accumulate.
REQ-024 When start and a pending flag coincide in IDLE, exactly one frame SHALL be sent and the pending flag SHALL be cleared.

Reset
REQ-025 On rst_n=0 the block SHALL immediately force state IDLE, tx_wr=0, tx_data=8'h00, busy=0, done=0, index=0, the auto counter to 0, pending=0 and the snapshot to 0.
REQ-026 A reset mid-frame SHALL abort the frame with no further strobes, and no resume after release.

Configuration
REQ-027 With FRAME_CHECKSUM_EN defined, the block SHALL insert '*' plus two uppercase ASCII hex digits of the XOR of the 15 payload bytes before CR LF, giving a 20-byte frame.
REQ-028 Without FRAME_CHECKSUM_EN, the frame SHALL be exactly 17 bytes and no checksum logic SHALL exist.

Structure
REQ-029 A shared package telemetry_pkg SHALL hold the FSM state encoding, the ASCII constants ('T','H','S','.',',','*',CR,LF), and FRAME_LEN_BASE=17 and FRAME_LEN_CSUM=20.
REQ-030 A sub-module nibble_to_ascii (4-bit to '0'-'9'/'A'-'F') SHALL be instantiated twice, and only under FRAME_CHECKSUM_EN.

Verification
REQ-031 te="235", hu="067", sm="128", start pulse, a UART model raising busy for 10 cycles per byte -> bytes "T23.5,H067,S128\r\n" and done once.
REQ-032 Same stimulus with FRAME_CHECKSUM_EN -> bytes "T23.5,H067,S128*" plus the computed XOR as 2 hex chars, then CR LF, for 20 bytes in total.
REQ-033 Change te_data to "999" after the 3rd strobe -> the frame still carries "T23.5".
REQ-034 A second start 5 cycles after the first -> exactly one frame; with tx_busy stuck low -> each byte advances after ACK_TIMEOUT=64 cycles.
REQ-035 AUTO_PERIOD=1000, tx model slow enough that frames exceed 1000 cycles -> frames back-to-back with no duplicate queued frames.
REQ-036 Assert rst_n=0 during byte 7 -> tx_wr=0 and busy=0 immediately, with no further bytes after release until a new start.

Source files
------------

// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry frame generator.
// Holds the framer FSM state encoding, the fixed ASCII characters that appear
// in every frame, and the two possible frame lengths (plain and checksummed).
package telemetry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } state_t;

  localparam logic [7:0] ASCII_T     = 8'h54;  // 'T'
  localparam logic [7:0] ASCII_H     = 8'h48;  // 'H'
  localparam logic [7:0] ASCII_S     = 8'h53;  // 'S'
  localparam logic [7:0] ASCII_DOT   = 8'h2E;  // '.'
  localparam logic [7:0] ASCII_COMMA = 8'h2C;  // ','
  localparam logic [7:0] ASCII_STAR  = 8'h2A;  // '*'
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned FRAME_LEN_BASE = 17;
  localparam int unsigned FRAME_LEN_CSUM = 20;

endpackage

// File: rtl/nibble_to_ascii.sv
// Converts a 4-bit value to its uppercase ASCII hex digit ('0'-'9', 'A'-'F').
// Ports:
//   i_nibble - value to convert
//   o_ascii  - ASCII character
module nibble_to_ascii (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // 'A' is 8'h41, so values 10..15 map onto 8'h37 + value.
  always_comb begin
    if (i_nibble < 4'd10) o_ascii = 8'h30 + {4'h0, i_nibble};
    else                  o_ascii = 8'h37 + {4'h0, i_nibble};
  end

endmodule

// File: rtl/telemetry_framer.sv
// Telemetry framer: serialises a snapshot of three 3-digit ASCII readings
// into the frame "Tdd.d,Hddd,Sddd" + CR LF, one byte at a time, handshaking
// with a UART transmitter through tx_wr / tx_busy.
//
// Build option: define FRAME_CHECKSUM_EN to append '*' and two uppercase hex
// digits (XOR of the 15 payload bytes) before CR LF, giving 20 bytes.
//
// Parameters:
//   AUTO_PERIOD - cycles between self-triggered frames (0 disables)
//   ACK_TIMEOUT - cycles to wait for tx_busy to rise after a strobe
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   start                       - one-cycle frame request (ignored while busy)
//   te_data, hu_data, sm_data   - three ASCII digits each, MSB byte first
//   tx_busy                     - UART is shifting a byte
//   tx_data, tx_wr              - byte to UART and its one-cycle write strobe
//   busy                        - frame in progress
//   done                        - one-cycle pulse after the last byte
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter logic [31:0] AUTO_PERIOD = 32'd0,
  parameter logic [15:0] ACK_TIMEOUT = 16'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] te_data,
  input  logic [23:0] hu_data,
  input  logic [23:0] sm_data,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  output logic        busy,
  output logic        done
);

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  state_t      r_state, w_next_state;
  logic [4:0]  r_index;
  logic [15:0] r_ack_cnt;
  logic [7:0]  r_tx_data;
  logic [23:0] r_te, r_hu, r_sm;
  logic        r_pending;
  logic        w_auto_fire;
  logic        w_accept;
  logic        w_adv;
  logic [4:0]  w_sel_idx;
  logic [7:0]  w_byte;

  assign w_accept = (r_state == IDLE) && (start || r_pending);

  // tx_data is registered and loaded as the FSM enters STROBE, so the byte is
  // already stable when the combinational tx_wr strobe fires and it holds
  // until the following byte is staged.
  assign w_adv     = (r_state == LOAD) ||
                     ((r_state == WAIT_DONE) && !tx_busy && (r_index != LAST_IDX));
  assign w_sel_idx = (r_state == LOAD) ? 5'd0 : r_index + 5'd1;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] w_csum, w_csum_hi, w_csum_lo;

  // The two commas cancel in the XOR but are kept so the expression reads as
  // the payload it covers.
  assign w_csum = ASCII_T ^ r_te[23:16] ^ r_te[15:8] ^ ASCII_DOT ^ r_te[7:0] ^
                  ASCII_COMMA ^ ASCII_H ^ r_hu[23:16] ^ r_hu[15:8] ^ r_hu[7:0] ^
                  ASCII_COMMA ^ ASCII_S ^ r_sm[23:16] ^ r_sm[15:8] ^ r_sm[7:0];

  nibble_to_ascii u_hex_hi (.i_nibble(w_csum[7:4]), .o_ascii(w_csum_hi));
  nibble_to_ascii u_hex_lo (.i_nibble(w_csum[3:0]), .o_ascii(w_csum_lo));
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_byte = ASCII_LF;
    case (w_sel_idx)
      5'd0:    w_byte = ASCII_T;
      5'd1:    w_byte = r_te[23:16];
      5'd2:    w_byte = r_te[15:8];
      5'd3:    w_byte = ASCII_DOT;
      5'd4:    w_byte = r_te[7:0];
      5'd5:    w_byte = ASCII_COMMA;
      5'd6:    w_byte = ASCII_H;
      5'd7:    w_byte = r_hu[23:16];
      5'd8:    w_byte = r_hu[15:8];
      5'd9:    w_byte = r_hu[7:0];
      5'd10:   w_byte = ASCII_COMMA;
      5'd11:   w_byte = ASCII_S;
      5'd12:   w_byte = r_sm[23:16];
      5'd13:   w_byte = r_sm[15:8];
      5'd14:   w_byte = r_sm[7:0];
`ifdef FRAME_CHECKSUM_EN
      5'd15:   w_byte = ASCII_STAR;
      5'd16:   w_byte = w_csum_hi;
      5'd17:   w_byte = w_csum_lo;
      5'd18:   w_byte = ASCII_CR;
`else
      5'd15:   w_byte = ASCII_CR;
`endif
      default: w_byte = ASCII_LF;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_next_state = LOAD;
      LOAD:      w_next_state = STROBE;
      STROBE:    if (!tx_busy) w_next_state = WAIT_ACK;
      // A transmitter that never acknowledges must not stall the frame.
      WAIT_ACK:  if (tx_busy || (r_ack_cnt == ACK_TIMEOUT - 16'd1))
                   w_next_state = WAIT_DONE;
      WAIT_DONE: if (!tx_busy)
                   w_next_state = (r_index == LAST_IDX) ? FINISH : STROBE;
      FINISH:    w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  assign tx_wr   = (r_state == STROBE) && !tx_busy;
  assign tx_data = r_tx_data;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == FINISH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_ack_cnt <= '0;
      r_tx_data <= '0;
      r_te      <= '0;
      r_hu      <= '0;
      r_sm      <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_te <= te_data;
        r_hu <= hu_data;
        r_sm <= sm_data;
      end
      if (w_adv) begin
        r_index   <= w_sel_idx;
        r_tx_data <= w_byte;
      end
      if (r_state == WAIT_ACK) r_ack_cnt <= r_ack_cnt + 16'd1;
      else                     r_ack_cnt <= '0;
      // Single-entry request: wraps while already pending collapse into one.
      r_pending <= w_auto_fire | (r_pending & ~w_accept);
    end
  end

  generate
    if (AUTO_PERIOD != 32'd0) begin : g_auto
      logic [31:0] r_auto_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_auto_cnt <= '0;
        else if (r_auto_cnt == AUTO_PERIOD - 32'd1) r_auto_cnt <= '0;
        else                                       r_auto_cnt <= r_auto_cnt + 32'd1;
      end

      assign w_auto_fire = (r_auto_cnt == AUTO_PERIOD - 32'd1);
    end else begin : g_no_auto
      assign w_auto_fire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_telemetry_framer.sv
`timescale 1ns/1ps
module tb_telemetry_framer;

  localparam int ACK_TO = 64;
  localparam int AUTO_P = 1000;
`ifdef FRAME_CHECKSUM_EN
  localparam int FLEN = 20;
`else
  localparam int FLEN = 17;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: no auto trigger, default timeout.
  logic        rst_n, start, tx_busy;
  logic [23:0] te, hu, sm;
  logic [7:0]  tx_data;
  logic        tx_wr, busy, done;

  // Instance B: auto trigger every AUTO_P cycles, shares the data inputs.
  logic        rst_n_b, start_b, tx_busy_b;
  logic [7:0]  tx_data_b;
  logic        tx_wr_b, busy_b, done_b;

  telemetry_framer #(.AUTO_PERIOD(32'd0), .ACK_TIMEOUT(16'(ACK_TO))) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .te_data(te), .hu_data(hu), .sm_data(sm), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_wr(tx_wr), .busy(busy), .done(done)
  );

  telemetry_framer #(.AUTO_PERIOD(32'(AUTO_P)), .ACK_TIMEOUT(16'(ACK_TO))) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b),
    .te_data(te), .hu_data(hu), .sm_data(sm), .tx_busy(tx_busy_b),
    .tx_data(tx_data_b), .tx_wr(tx_wr_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic string add_tail(input string p);
    string r = p;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 0; i < p.len(); i++) x = x ^ p[i];
    r = {r, $sformatf("*%02X", x)};
`endif
    return {r, "\r\n"};
  endfunction

  function automatic string frame_model(input logic [23:0] t, input logic [23:0] h,
                                        input logic [23:0] s);
    return add_tail($sformatf("T%c%c.%c,H%c%c%c,S%c%c%c",
                              t[23:16], t[15:8], t[7:0], h[23:16], h[15:8], h[7:0],
                              s[23:16], s[15:8], s[7:0]));
  endfunction

  function automatic logic [23:0] rand_digits();
    logic [23:0] v;
    for (int i = 0; i < 3; i++) v[i*8 +: 8] = 8'h30 + 8'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- byte monitors (sampled mid-cycle) ----------------
  byte q_a[$];
  int  wc_a[$];
  int  done_a = 0;
  byte q_b[$];
  int  wc_b[$];
  int  done_cyc_b[$];
  int  done_bn = 0;

  always @(negedge clk) begin
    if (tx_wr) begin q_a.push_back(tx_data); wc_a.push_back(cyc); end
    if (done) done_a++;
    if (tx_wr_b) begin q_b.push_back(tx_data_b); wc_b.push_back(cyc); end
    if (done_b) begin done_bn++; done_cyc_b.push_back(cyc); end
  end

  // ---------------- UART models ----------------
  int blen_a = 10;
  bit ack_en_a = 1'b1;
  int blen_b = 2;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_wr && ack_en_a) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (blen_a) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    tx_busy_b = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_wr_b) begin
        @(posedge clk); #1 tx_busy_b = 1'b1;
        repeat (blen_b) @(posedge clk);
        #1 tx_busy_b = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_a();
    q_a.delete(); wc_a.delete(); done_a = 0;
  endtask

  task automatic pulse_start(output int s_cyc);
    @(posedge clk); #1 start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int budget);
    int n = 0;
    while (done_a == 0 && n < budget) begin @(posedge clk); n++; end
    repeat (10) @(posedge clk);
    check({name, " done pulses"}, done_a, 1);
  endtask

  task automatic cmp_bytes(input string name, input byte got[$], input int off,
                           input string exp);
    int bad = -1;
    for (int i = 0; i < exp.len(); i++)
      if (bad < 0 && (off + i >= got.size() || got[off + i] != exp[i])) bad = i;
    check({name, " first wrong byte index"}, bad, -1);
  endtask

  typedef struct {
    logic [23:0] te;
    logic [23:0] hu;
    logic [23:0] sm;
    string       payload;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, n, bad, base, gap;
    string name;

    vecs[0] = '{"235", "067", "128", "T23.5,H067,S128"};
    vecs[1] = '{"000", "000", "000", "T00.0,H000,S000"};
    vecs[2] = '{"999", "100", "050", "T99.9,H100,S050"};

    rst_n = 1'b0; rst_n_b = 1'b0; start = 1'b0; start_b = 1'b0;
    te = '0; hu = '0; sm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_wr", tx_wr, 0);
    check("reset tx_data", tx_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset b busy", busy_b, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Table-driven frames with a 10-cycle UART.
    for (int v = 0; v < 3; v++) begin
      name = $sformatf("vec%0d", v);
      te = vecs[v].te; hu = vecs[v].hu; sm = vecs[v].sm;
      clear_a();
      pulse_start(s);
      wait_done_a(name, 2000);
      check({name, " byte count"}, q_a.size(), FLEN);
      cmp_bytes(name, q_a, 0, add_tail(vecs[v].payload));
      check({name, " start to first tx_wr"}, wc_a.size() > 0 ? wc_a[0] - s : -1, 2);
    end

    // Randomised frames and UART busy lengths.
    for (int r = 0; r < 4; r++) begin
      name = $sformatf("rand%0d", r);
      te = rand_digits(); hu = rand_digits(); sm = rand_digits();
      blen_a = int'($urandom_range(1, 12));
      clear_a();
      pulse_start(s);
      wait_done_a(name, 3000);
      check({name, " byte count"}, q_a.size(), FLEN);
      cmp_bytes(name, q_a, 0, frame_model(te, hu, sm));
    end
    blen_a = 10;

    // Inputs change after the third strobe; the snapshot must be used.
    te = "235"; hu = "067"; sm = "128";
    clear_a();
    pulse_start(s);
    n = 0;
    while (q_a.size() < 3 && n < 500) begin @(posedge clk); n++; end
    te = "999";
    wait_done_a("snapshot", 2000);
    cmp_bytes("snapshot", q_a, 0, add_tail("T23.5,H067,S128"));

    // Second start 5 cycles after the first is dropped, not queued.
    te = "235";
    clear_a();
    pulse_start(s);
    repeat (3) @(posedge clk);
    pulse_start(s);
    wait_done_a("double start", 2000);
    repeat (200) @(posedge clk);
    check("double start byte count", q_a.size(), FLEN);
    check("double start done count", done_a, 1);

    // tx_busy stuck low: every byte advances on the acknowledge timeout.
    ack_en_a = 1'b0;
    clear_a();
    pulse_start(s);
    wait_done_a("stuck low", FLEN * (ACK_TO + 10));
    check("stuck low byte count", q_a.size(), FLEN);
    cmp_bytes("stuck low", q_a, 0, frame_model(te, hu, sm));
    bad = 0;
    for (int i = 1; i < wc_a.size(); i++)
      if (wc_a[i] - wc_a[i-1] < ACK_TO || wc_a[i] - wc_a[i-1] > ACK_TO + 3) bad++;
    check("stuck low strobe spacing violations", bad, 0);
    ack_en_a = 1'b1;

    // Reset during byte 7 aborts the frame for good.
    clear_a();
    pulse_start(s);
    n = 0;
    while (q_a.size() < 6 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_wr && n < 100) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    check("mid-frame reset tx_wr", tx_wr, 0);
    check("mid-frame reset busy", busy, 0);
    check("mid-frame reset tx_data", tx_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    check("after reset bytes sent", q_a.size(), 7);
    check("after reset done count", done_a, 0);
    clear_a();
    pulse_start(s);
    wait_done_a("post reset", 2000);
    check("post reset byte count", q_a.size(), FLEN);
    cmp_bytes("post reset", q_a, 0, frame_model(te, hu, sm));

    // Auto trigger: start coincides with the first pending request.
    te = "235"; hu = "067"; sm = "128";
    @(posedge clk); #1 rst_n_b = 1'b1;
    repeat (AUTO_P) @(posedge clk);
    #1 start_b = 1'b1; s = cyc;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (done_bn < 2 && n < 3 * AUTO_P) begin @(posedge clk); n++; end
    check("auto first two frames done", done_bn, 2);
    check("coincident start latency", wc_b.size() > 0 ? wc_b[0] - s : -1, 2);
    check("auto period spacing", wc_b.size() > FLEN ? wc_b[FLEN] - wc_b[0] : -1, AUTO_P);
    cmp_bytes("auto frame1", q_b, 0, frame_model(te, hu, sm));
    cmp_bytes("auto frame2", q_b, FLEN, frame_model(te, hu, sm));

    // Slow UART: frames longer than the period run back-to-back.
    blen_b = 90;
    n = 0;
    while (done_bn < 5 && n < 8000) begin @(posedge clk); n++; end
    check("slow auto frames done", done_bn, 5);
    bad = 0;
    for (int k = 3; k <= 4; k++) begin
      gap = (wc_b.size() > k * FLEN && done_cyc_b.size() >= k)
            ? wc_b[k * FLEN] - done_cyc_b[k-1] : -1;
      if (gap < 1 || gap > 4) bad++;
    end
    check("back-to-back gap violations", bad, 0);
    cmp_bytes("slow auto frame", q_b, 3 * FLEN, frame_model(te, hu, sm));

    // Fast again: only one pending request may have survived the slow phase.
    blen_b = 2;
    base = done_bn;
    repeat (3000) @(posedge clk);
    check("frames in 3000 cycles within 2..5", (done_bn - base >= 2) && (done_bn - base <= 5), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
